gate_mode_controller: RTL and testbench

//  Board-level controller for the two-button gate datapath: debounces the operand

---
 rtl/gate_mode_pkg.sv | 51 +++++
 rtl/button_debouncer.sv | 64 ++++++
 rtl/gate_mode_controller.sv | 129 ++++++++++++
 tb/tb_gate_mode_controller.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_mode_pkg.sv
// -----------------------------------------------------------------------------
// gate_mode_pkg
//   Shared definitions for the gate mode controller: the mode encoding, the
//   mode sequence step and the 2-input logic function evaluated for each mode.
//   No ports (package).
// -----------------------------------------------------------------------------
package gate_mode_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_AND  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_XOR  = 3'd2,
    MODE_NAND = 3'd3,
    MODE_NOR  = 3'd4,
    MODE_XNOR = 3'd5
  } mode_e;

  localparam mode_e MODE_LAST = MODE_XNOR;

  // Next mode in the AND..XNOR ring; the unused codes 6 and 7 fall back to AND.
  function automatic mode_e mode_next(input mode_e mode);
    mode_e nxt;
    case (mode)
      MODE_AND:  nxt = MODE_OR;
      MODE_OR:   nxt = MODE_XOR;
      MODE_XOR:  nxt = MODE_NAND;
      MODE_NAND: nxt = MODE_NOR;
      MODE_NOR:  nxt = MODE_XNOR;
      default:   nxt = MODE_AND;
    endcase
    return nxt;
  endfunction

  // Logic function selected by the current mode.
  function automatic logic gate_eval(input mode_e mode, input logic a, input logic b);
    logic y;
    case (mode)
      MODE_AND:  y = a & b;
      MODE_OR:   y = a | b;
      MODE_XOR:  y = a ^ b;
      MODE_NAND: y = ~(a & b);
      MODE_NOR:  y = ~(a | b);
      MODE_XNOR: y = ~(a ^ b);
      default:   y = 1'b0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//   Two-flop synchroniser followed by a stability counter. The stable output
//   only follows the synchronised input once it has differed from the current
//   stable value for DEBOUNCE_CYCLES consecutive cycles; shorter glitches are
//   dropped.
// Ports:
//   CLK     in  system clock
//   RESET   in  asynchronous, active-high reset
//   raw     in  raw button pin, unsynchronised
//   stable  out debounced button level
// -----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic raw,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only runs while the input disagrees with the stable value, so
  // any return to agreement restarts the qualification window from zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // it unassigned would infer a latch.
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the pre-edge values; blocking here would collapse the
  // synchroniser into a single stage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable = stable_q;

endmodule

// File: rtl/gate_mode_controller.sv
// -----------------------------------------------------------------------------
// gate_mode_controller
//   Board-level controller: debounces two operand buttons and a mode button,
//   steps through six 2-input logic functions on each mode-button press and
//   drives the result LED plus a flash LED that lights after every mode change.
// Ports:
//   CLK       in   system clock
//   RESET     in   asynchronous, active-high reset
//   BTN[1:0]  in   raw operand buttons, a = BTN[0], b = BTN[1]
//   BTN_MODE  in   raw mode-advance button
//   LED[1:0]  out  LED[0] = f(a,b) under current mode, LED[1] = mode-change flash
//   MODE[2:0] out  current mode code 0..5
// Configuration:
//   GATE_AUTO_CYCLE_EN  when defined, a free-running timer also advances the
//                       mode every AUTO_PERIOD cycles; manual advances restart it.
// -----------------------------------------------------------------------------
module gate_mode_controller
  import gate_mode_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FLASH_CYCLES    = 12500000,
  parameter int unsigned AUTO_PERIOD     = 50000000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        BTN,
  input  logic              BTN_MODE,
  output logic [1:0]        LED,
  output logic [MODE_W-1:0] MODE
);

  localparam int unsigned FLASH_W = $clog2(FLASH_CYCLES + 1);
  localparam logic [FLASH_W-1:0] FLASH_LOAD = FLASH_W'(FLASH_CYCLES);

  logic a_deb, b_deb, mode_btn_deb;

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .CLK    (CLK),
    .RESET  (RESET),
    .raw    (BTN[0]),
    .stable (a_deb)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .CLK    (CLK),
    .RESET  (RESET),
    .raw    (BTN[1]),
    .stable (b_deb)
  );

  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_mode (
    .CLK    (CLK),
    .RESET  (RESET),
    .raw    (BTN_MODE),
    .stable (mode_btn_deb)
  );

  logic               mode_btn_q;
  logic               manual_adv, auto_tick, advance;
  mode_e              mode_q, mode_d;
  logic [FLASH_W-1:0] flash_q, flash_d;
  logic [1:0]         led_q, led_d;

  // Rising edge of the debounced mode button only: holding or releasing it
  // produces no further advance.
  assign manual_adv = mode_btn_deb & ~mode_btn_q;

`ifdef GATE_AUTO_CYCLE_EN
  localparam int unsigned AUTO_W = $clog2(AUTO_PERIOD + 1);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_PERIOD - 1);

  logic [AUTO_W-1:0] auto_q;

  assign auto_tick = (auto_q == AUTO_LAST);

  // Any advance (manual or the tick itself) restarts the period from zero, so
  // a press landing on the tick cycle still yields a single step.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      auto_q <= '0;
    end else if (advance) begin
      auto_q <= '0;
    end else begin
      auto_q <= auto_q + 1'b1;
    end
  end
`else
  assign auto_tick = 1'b0;
`endif

  assign advance = manual_adv | auto_tick;

  always_comb begin
    mode_d = mode_q;
    // mode_next maps the unreachable codes back to AND, which also covers
    // recovery without an advance.
    if (advance || (mode_q > MODE_LAST)) begin
      mode_d = mode_next(mode_q);
    end

    if (advance) begin
      flash_d = FLASH_LOAD;
    end else if (flash_q != '0) begin
      flash_d = flash_q - 1'b1;
    end else begin
      flash_d = '0;
    end

    led_d = {(flash_d != '0), gate_eval(mode_q, a_deb, b_deb)};
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mode_btn_q <= 1'b0;
      mode_q     <= MODE_AND;
      flash_q    <= '0;
      led_q      <= 2'b00;
    end else begin
      mode_btn_q <= mode_btn_deb;
      mode_q     <= mode_d;
      flash_q    <= flash_d;
      led_q      <= led_d;
    end
  end

  assign LED  = led_q;
  assign MODE = mode_q;

endmodule

// File: tb/tb_gate_mode_controller.sv
// -----------------------------------------------------------------------------
// tb_gate_mode_controller
//   Directed scenarios with literal expectations followed by randomized button
//   activity. A behavioural model derived from the button/mode/flash rules
//   predicts LED and MODE; a compare process checks them on every falling edge.
//   Define GATE_AUTO_CYCLE_EN to also exercise the automatic mode timer.
// -----------------------------------------------------------------------------
module tb_gate_mode_controller;

  localparam int DB = 4;
  localparam int FL = 8;
  localparam int AP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] btn = 2'b00;
  logic       btn_mode = 1'b0;
  logic [1:0] led;
  logic [2:0] mode;

  int checks = 0;
  int errors = 0;

  gate_mode_controller #(
    .DEBOUNCE_CYCLES (DB),
    .FLASH_CYCLES    (FL),
    .AUTO_PERIOD     (AP)
  ) dut (
    .CLK      (clk),
    .RESET    (rst),
    .BTN      (btn),
    .BTN_MODE (btn_mode),
    .LED      (led),
    .MODE     (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model.
  //   - each raw pin reaches the debouncer two samples late;
  //   - the debounced level flips once the last DB delayed samples all show
  //     the opposite level;
  //   - LED[0] is a truth-table lookup of (mode, a, b) one cycle later;
  //   - a mode step happens when the debounced mode level goes 0 -> 1 (or on
  //     an auto tick), and the flash LED stays lit for FL cycles afterwards.
  // ---------------------------------------------------------------------------
  bit [3:0] tt [6] = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001};

  bit [1:0] dly [3];
  bit       win [3][DB];
  bit       deb [3];
  bit       deb_mode_last;
  bit       raw_s [3];
  int       m_mode, m_flash, m_idle;
  bit       m_led0, m_led1;
  bit       m_adv, m_tick, m_all, m_seen;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 3; b++) begin
        dly[b] = 2'b00;
        deb[b] = 1'b0;
        for (int k = 0; k < DB; k++) win[b][k] = 1'b0;
      end
      deb_mode_last = 1'b0;
      m_mode = 0; m_flash = 0; m_idle = 0;
      m_led0 = 1'b0; m_led1 = 1'b0;
    end else begin
      raw_s[0] = btn[0]; raw_s[1] = btn[1]; raw_s[2] = btn_mode;
      m_led0 = tt[m_mode][{deb[0], deb[1]}];
      m_adv = deb[2] && !deb_mode_last;
      deb_mode_last = deb[2];
`ifdef GATE_AUTO_CYCLE_EN
      m_tick = (m_idle == AP - 1);
`else
      m_tick = 1'b0;
`endif
      m_adv = m_adv || m_tick;
      m_idle = m_adv ? 0 : m_idle + 1;
      if (m_adv) m_mode = (m_mode + 1) % 6;
      m_flash = m_adv ? FL : ((m_flash > 0) ? m_flash - 1 : 0);
      m_led1 = (m_flash != 0);
      for (int b = 0; b < 3; b++) begin
        m_seen = dly[b][1];
        dly[b] = {dly[b][0], raw_s[b]};
        for (int k = 0; k < DB - 1; k++) win[b][k] = win[b][k+1];
        win[b][DB-1] = m_seen;
        m_all = 1'b1;
        for (int k = 0; k < DB; k++) if (win[b][k] == deb[b]) m_all = 1'b0;
        if (m_all) deb[b] = !deb[b];
      end
    end
  end

  always @(negedge clk) begin
    check("model_led", {30'd0, led}, {30'd0, m_led1, m_led0});
    check("model_mode", {29'd0, mode}, m_mode);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------------------
  // Directed + random stimulus
  // ---------------------------------------------------------------------------
  int cnt, changes, prev_mode, r, hold;
  int exp_mode [6] = '{1, 2, 3, 4, 5, 0};
  int exp_led0 [6] = '{1, 1, 1, 0, 0, 0};

  initial begin
    #1 rst = 1'b1;
    #20;
    @(negedge clk) rst = 1'b0;
    check("reset_led", {30'd0, led}, 32'd0);
    check("reset_mode", {29'd0, mode}, 32'd0);

    // AND mode, both operands pressed: LED[0] rises exactly 7 edges later
    btn = 2'b11;
    repeat (6) @(posedge clk);
    #1 check("and11_edge6", {31'd0, led[0]}, 32'd0);
    @(posedge clk);
    #1 check("and11_edge7", {31'd0, led[0]}, 32'd1);
    @(negedge clk) btn = 2'b01;
    repeat (10) @(negedge clk);
    check("and01", {31'd0, led[0]}, 32'd0);

    // b held, a glitches: 3-cycle pulse dropped, 4-cycle pulse accepted
    btn = 2'b10;
    repeat (10) @(negedge clk);
    cnt = 0;
    btn[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 2) btn[0] = 1'b0;
      if (led[0]) cnt++;
    end
    check("glitch3_dropped", cnt, 0);
    cnt = 0;
    btn[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 3) btn[0] = 1'b0;
      if (led[0]) cnt++;
    end
    check("pulse4_accepted", cnt, 4);

    // six clean presses walk the full mode ring with a = 1, b = 0
    btn = 2'b01;
    for (int p = 0; p < 6; p++) begin
      btn_mode = 1'b1;
      cnt = 0;
      for (int i = 0; i < 24; i++) begin
        @(negedge clk);
        if (i == 9) btn_mode = 1'b0;
        if (led[1]) cnt++;
      end
      check("press_flash_len", cnt, 8);
      check("press_mode", {29'd0, mode}, exp_mode[p]);
      check("press_led0", {31'd0, led[0]}, exp_led0[p]);
    end

    // long hold gives a single advance
    btn_mode = 1'b1;
    changes = 0;
    prev_mode = int'(mode);
    repeat (100) begin
      @(negedge clk);
      if (int'(mode) != prev_mode) changes++;
      prev_mode = int'(mode);
    end
    btn_mode = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (int'(mode) != prev_mode) changes++;
      prev_mode = int'(mode);
    end
    check("hold_one_advance", changes, 1);
    check("hold_mode", {29'd0, mode}, 32'd1);

    // reset in the middle of a flash, without a clock edge
    btn_mode = 1'b1;
    repeat (5) @(negedge clk);
    btn_mode = 1'b0;
    repeat (4) @(negedge clk);
    check("flash_active", {31'd0, led[1]}, 32'd1);
    check("flash_mode", {29'd0, mode}, 32'd2);
    #2 rst = 1'b1;
    #1 check("async_reset_led", {30'd0, led}, 32'd0);
    check("async_reset_mode", {29'd0, mode}, 32'd0);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    changes = 0;
    repeat (30) begin
      @(negedge clk);
      if (led[1]) cnt++;
      if (mode != 3'd0) changes++;
    end
    check("post_reset_no_flash", cnt, 0);
    check("post_reset_no_advance", changes, 0);

`ifdef GATE_AUTO_CYCLE_EN
    // auto step after 32 idle edges; a press landing on the tick steps once
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (31) @(posedge clk);
    #1 check("auto_before_tick", {29'd0, mode}, 32'd0);
    @(posedge clk);
    #1 check("auto_tick", {29'd0, mode}, 32'd1);
    repeat (25) @(posedge clk);
    @(negedge clk) btn_mode = 1'b1;
    repeat (6) @(posedge clk);
    #1 check("coincide_before", {29'd0, mode}, 32'd1);
    @(posedge clk);
    #1 check("coincide_once", {29'd0, mode}, 32'd2);
    @(negedge clk) btn_mode = 1'b0;
    repeat (31) @(posedge clk);
    #1 check("restart_before", {29'd0, mode}, 32'd2);
    @(posedge clk);
    #1 check("restart_tick", {29'd0, mode}, 32'd3);
    @(negedge clk);
`endif

    // randomized activity, checked only by the model comparison
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk) rst = 1'b0;
      end else if (r < 35) begin
        btn_mode = ~btn_mode;
        hold = int'($urandom_range(1, 12));
        repeat (hold) @(negedge clk);
      end else begin
        btn = 2'($urandom);
        hold = int'($urandom_range(1, 10));
        repeat (hold) @(negedge clk);
      end
    end

    repeat (20) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
